// File: rtl/rf_feature_window_if.sv
// Feature-window bus: event inputs, feature outputs and the ROM-walker start/done handshake.
// The master modport is the feature-window block; the slave modport is its environment.
interface rf_feature_window_if;
  logic       en;
  logic       ev_req;
  logic       ev_llc_acc;
  logic       ev_llc_miss;
  logic       ev_q_high;
  logic       ev_rb_hit;
  logic       ev_rb_empty;
  logic       ev_rb_conf;
  logic [7:0] req_per_cycle;
  logic [7:0] conflict_load;
  logic [7:0] llc_miss;
  logic [7:0] traffic_risk;
  logic [7:0] rb_locality;
  logic [7:0] rb_conflict;
  logic       walk_start;
  logic       walk_done;
  logic [7:0] walk_t_refi;
  logic [7:0] t_refi_out;
  logic       t_refi_valid;
  logic [7:0] overrun_cnt;

  modport master (
    input  en, ev_req, ev_llc_acc, ev_llc_miss, ev_q_high,
    input  ev_rb_hit, ev_rb_empty, ev_rb_conf, walk_done, walk_t_refi,
    output req_per_cycle, conflict_load, llc_miss, traffic_risk,
    output rb_locality, rb_conflict, walk_start, t_refi_out, t_refi_valid, overrun_cnt
  );

  modport slave (
    output en, ev_req, ev_llc_acc, ev_llc_miss, ev_q_high,
    output ev_rb_hit, ev_rb_empty, ev_rb_conf, walk_done, walk_t_refi,
    input  req_per_cycle, conflict_load, llc_miss, traffic_risk,
    input  rb_locality, rb_conflict, walk_start, t_refi_out, t_refi_valid, overrun_cnt
  );
endinterface

// File: rtl/rf_feature_window.sv
// Counts memory-controller events over back-to-back windows of 2**WIN_LOG2 cycles and turns each
// window into six 8-bit features (shifts plus a shared 9-bit serial divider) for the tREFI walker.
module rf_feature_window #(
  parameter int WIN_LOG2 = 10
) (
  input logic                 clk,
  input logic                 rst,
  rf_feature_window_if.master bus
);
  localparam int CW = WIN_LOG2 + 1;
  localparam int DW = WIN_LOG2 + 3;
  localparam int RW = DW + 1;
  localparam logic [WIN_LOG2-1:0] WIN_LAST = {WIN_LOG2{1'b1}};
  localparam logic [WIN_LOG2-1:0] WIN_ONE  = WIN_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV      = 2'd1,
    ST_START    = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  function automatic logic [7:0] shift_sat(input logic [CW-1:0] n);
    logic [CW-1:0] s;
    s = n >> (WIN_LOG2 - 8);
    return (s > CW'(255)) ? 8'd255 : s[7:0];
  endfunction

  function automatic logic [7:0] ratio_sat(input logic [8:0] q, input logic den_zero);
    logic [7:0] r;
    if (den_zero) begin
      r = 8'd0;
    end else if (q[8]) begin
      r = 8'd255;
    end else begin
      r = q[7:0];
    end
    return r;
  endfunction

  // Event index order: req, llc_acc, llc_miss, q_high, rb_hit, rb_empty, rb_conf.
  logic [6:0]          ev_s;
  logic [WIN_LOG2-1:0] win_cnt_r;
  logic [CW-1:0]       cnt_r     [0:6];
  logic [CW-1:0]       cnt_inc_s [0:6];
  logic                close_s;

  state_t        state_r;
  logic [RW-1:0] rem_r;
  logic [DW-1:0] den_r;
  logic [8:0]    quo_r;
  logic [3:0]    bit_r;
  logic [1:0]    sel_r;
  logic [CW-1:0] snap_hit_r;
  logic [CW-1:0] snap_conf_r;
  logic [DW-1:0] snap_rbsum_r;
  logic [7:0]    snap_req_r;
  logic [7:0]    snap_load_r;
  logic [7:0]    snap_risk_r;
  logic [7:0]    q_miss_r;
  logic [7:0]    q_loc_r;
  logic [7:0]    feat_req_r;
  logic [7:0]    feat_load_r;
  logic [7:0]    feat_miss_r;
  logic [7:0]    feat_risk_r;
  logic [7:0]    feat_loc_r;
  logic [7:0]    feat_conf_r;
  logic          walk_start_r;
  logic [7:0]    t_refi_r;
  logic          t_refi_valid_r;
  logic [7:0]    overrun_r;

  logic [RW-1:0] rem_sub_s;
  logic [RW-1:0] rem_next_s;
  logic          q_bit_s;
  logic [8:0]    quo_next_s;
  logic          den_zero_s;

  assign ev_s = {bus.ev_rb_conf, bus.ev_rb_empty, bus.ev_rb_hit, bus.ev_q_high,
                 bus.ev_llc_miss, bus.ev_llc_acc, bus.ev_req};
  assign close_s = bus.en && (win_cnt_r == WIN_LAST);

  // Per-event increment including the current cycle, so the close cycle lands in the snapshot.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      cnt_inc_s[i] = cnt_r[i] + {{(CW-1){1'b0}}, ev_s[i]};
    end
  end

  // One restoring-division step: compare, conditionally subtract, shift in a quotient bit.
  always_comb begin
    rem_sub_s  = rem_r - {1'b0, den_r};
    q_bit_s    = (rem_r >= {1'b0, den_r});
    den_zero_s = (den_r == {DW{1'b0}});
    if (q_bit_s) begin
      rem_next_s = rem_sub_s;
    end else begin
      rem_next_s = rem_r;
    end
    quo_next_s = {quo_r[7:0], q_bit_s};
  end

  // Window position and event counters; cleared while disabled and restarted on every close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_r <= {WIN_LOG2{1'b0}};
      for (int i = 0; i < 7; i++) cnt_r[i] <= {CW{1'b0}};
    end else if (!bus.en || close_s) begin
      win_cnt_r <= {WIN_LOG2{1'b0}};
      for (int i = 0; i < 7; i++) cnt_r[i] <= {CW{1'b0}};
    end else begin
      win_cnt_r <= win_cnt_r + WIN_ONE;
      for (int i = 0; i < 7; i++) cnt_r[i] <= cnt_inc_s[i];
    end
  end

  // Snapshot/overrun handling, serial divider and walker handshake FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      rem_r          <= {RW{1'b0}};
      den_r          <= {DW{1'b0}};
      quo_r          <= 9'd0;
      bit_r          <= 4'd0;
      sel_r          <= 2'd0;
      snap_hit_r     <= {CW{1'b0}};
      snap_conf_r    <= {CW{1'b0}};
      snap_rbsum_r   <= {DW{1'b0}};
      snap_req_r     <= 8'd0;
      snap_load_r    <= 8'd0;
      snap_risk_r    <= 8'd0;
      q_miss_r       <= 8'd0;
      q_loc_r        <= 8'd0;
      feat_req_r     <= 8'd0;
      feat_load_r    <= 8'd0;
      feat_miss_r    <= 8'd0;
      feat_risk_r    <= 8'd0;
      feat_loc_r     <= 8'd0;
      feat_conf_r    <= 8'd0;
      walk_start_r   <= 1'b0;
      t_refi_r       <= 8'd32;
      t_refi_valid_r <= 1'b0;
      overrun_r      <= 8'd0;
    end else begin
      t_refi_valid_r <= 1'b0;
      // A window is only accepted by an idle FSM with the walker released; otherwise it is dropped.
      if (close_s && !((state_r == ST_IDLE) && !bus.walk_done) && (overrun_r != 8'd255)) begin
        overrun_r <= overrun_r + 8'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (close_s && !bus.walk_done) begin
            rem_r        <= RW'(cnt_inc_s[2]);
            den_r        <= DW'(cnt_inc_s[1]);
            quo_r        <= 9'd0;
            bit_r        <= 4'd0;
            sel_r        <= 2'd0;
            snap_hit_r   <= cnt_inc_s[4];
            snap_conf_r  <= cnt_inc_s[6];
            snap_rbsum_r <= DW'(cnt_inc_s[4]) + DW'(cnt_inc_s[5]) + DW'(cnt_inc_s[6]);
            snap_req_r   <= shift_sat(cnt_inc_s[0]);
            snap_load_r  <= shift_sat(cnt_inc_s[6]);
            snap_risk_r  <= shift_sat(cnt_inc_s[3]);
            state_r      <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (bit_r == 4'd8) begin
            bit_r <= 4'd0;
            quo_r <= 9'd0;
            case (sel_r)
              2'd0: begin
                q_miss_r <= ratio_sat(quo_next_s, den_zero_s);
                rem_r    <= RW'(snap_hit_r);
                den_r    <= snap_rbsum_r;
                sel_r    <= 2'd1;
              end
              2'd1: begin
                q_loc_r <= ratio_sat(quo_next_s, den_zero_s);
                rem_r   <= RW'(snap_conf_r);
                sel_r   <= 2'd2;
              end
              default: begin
                feat_req_r  <= snap_req_r;
                feat_load_r <= snap_load_r;
                feat_risk_r <= snap_risk_r;
                feat_miss_r <= q_miss_r;
                feat_loc_r  <= q_loc_r;
                feat_conf_r <= ratio_sat(quo_next_s, den_zero_s);
                sel_r       <= 2'd0;
                state_r     <= ST_START;
              end
            endcase
          end else begin
            bit_r <= bit_r + 4'd1;
            rem_r <= {rem_next_s[RW-2:0], 1'b0};
            quo_r <= quo_next_s;
          end
        end
        ST_START: begin
          if (!walk_start_r) begin
            if (!bus.walk_done) begin
              walk_start_r <= 1'b1;
            end
          end else if (bus.walk_done) begin
            walk_start_r   <= 1'b0;
            t_refi_r       <= bus.walk_t_refi;
            t_refi_valid_r <= 1'b1;
            state_r        <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!bus.walk_done) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          walk_start_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_per_cycle = feat_req_r;
  assign bus.conflict_load = feat_load_r;
  assign bus.llc_miss      = feat_miss_r;
  assign bus.traffic_risk  = feat_risk_r;
  assign bus.rb_locality   = feat_loc_r;
  assign bus.rb_conflict   = feat_conf_r;
  assign bus.walk_start    = walk_start_r;
  assign bus.t_refi_out    = t_refi_r;
  assign bus.t_refi_valid  = t_refi_valid_r;
  assign bus.overrun_cnt   = overrun_r;
endmodule

// File: tb/tb_rf_feature_window.sv
// Randomized self-checking bench for rf_feature_window (W=256) against an arithmetic window model
// and a walker model that answers done 3 cycles after start.
module tb_rf_feature_window;
  localparam int WL = 8;
  localparam int W  = 1 << WL;

  typedef struct packed {
    logic [7:0] req;
    logic [7:0] load;
    logic [7:0] miss;
    logic [7:0] risk;
    logic [7:0] loc;
    logic [7:0] conf;
  } feat_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  int   model_t_refi;
  bit   stall;
  int   exp_overrun;

  rf_feature_window_if bus ();

  rf_feature_window #(.WIN_LOG2(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] shift_ref(input int n);
    int v;
    v = (n * 256) / W;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  function automatic logic [7:0] ratio_ref(input int n, input int d);
    int v;
    if (d == 0) return 8'd0;
    v = (n * 256) / d;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  task automatic check_feat(input string tag, input feat_t e);
    check_eq({tag, "_req_per_cycle"}, bus.req_per_cycle, e.req);
    check_eq({tag, "_conflict_load"}, bus.conflict_load, e.load);
    check_eq({tag, "_llc_miss"},      bus.llc_miss,      e.miss);
    check_eq({tag, "_traffic_risk"},  bus.traffic_risk,  e.risk);
    check_eq({tag, "_rb_locality"},   bus.rb_locality,   e.loc);
    check_eq({tag, "_rb_conflict"},   bus.rb_conflict,   e.conf);
  endtask

  // Drives one full window of events (en=1) and returns the model's expected features.
  task automatic drive_window(input int mode, output feat_t e, output int close_c);
    int n_req, n_acc, n_miss, n_qh, n_hit, n_emp, n_conf;
    int p_req, p_qh, rb;
    logic r, a, m, q, h, em, c;
    n_req = 0; n_acc = 0; n_miss = 0; n_qh = 0; n_hit = 0; n_emp = 0; n_conf = 0;
    p_req = $urandom_range(0, 100);
    p_qh  = $urandom_range(0, 40);
    for (int i = 0; i < W; i++) begin
      r = 1'b0; a = 1'b0; m = 1'b0; q = 1'b0; h = 1'b0; em = 1'b0; c = 1'b0;
      case (mode)
        1: r = 1'b1;
        2: begin r = (i % 4 == 0); q = (i < 32); end
        3: begin a = (i < 200); m = (i < 50); h = (i < 30); em = (i >= 30 && i < 40); end
        5: begin h = (i == 0); c = (i == 1); end
        6: begin
          r  = ($urandom_range(0, 99) < p_req);
          q  = ($urandom_range(0, 99) < p_qh);
          a  = $urandom_range(0, 1);
          m  = a && ($urandom_range(0, 2) == 0);
          rb = $urandom_range(0, 3);
          h  = (rb == 1); em = (rb == 2); c = (rb == 3);
        end
        default: ;
      endcase
      bus.en = 1'b1;
      bus.ev_req = r; bus.ev_llc_acc = a; bus.ev_llc_miss = m; bus.ev_q_high = q;
      bus.ev_rb_hit = h; bus.ev_rb_empty = em; bus.ev_rb_conf = c;
      n_req += int'(r); n_acc += int'(a); n_miss += int'(m); n_qh += int'(q);
      n_hit += int'(h); n_emp += int'(em); n_conf += int'(c);
      @(posedge clk); #1;
    end
    bus.ev_req = 1'b0; bus.ev_llc_acc = 1'b0; bus.ev_llc_miss = 1'b0; bus.ev_q_high = 1'b0;
    bus.ev_rb_hit = 1'b0; bus.ev_rb_empty = 1'b0; bus.ev_rb_conf = 1'b0;
    close_c = cyc;
    e.req  = shift_ref(n_req);
    e.load = shift_ref(n_conf);
    e.risk = shift_ref(n_qh);
    e.miss = ratio_ref(n_miss, n_acc);
    e.loc  = ratio_ref(n_hit, n_hit + n_emp + n_conf);
    e.conf = ratio_ref(n_conf, n_hit + n_emp + n_conf);
  endtask

  // Follows one walk: start latency, features, optional walker stall, capture pulse.
  task automatic check_walk(input string tag, input feat_t e, input int close_c, input int stall_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus.walk_start) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_eq({tag, "_start_seen"}, seen, 1);
    check_eq({tag, "_start_latency"}, cyc - close_c, 28);
    check_feat(tag, e);
    if (stall_cyc > 0) begin
      stall = 1'b1;
      repeat (stall_cyc) begin @(posedge clk); #1; end
      check_eq({tag, "_start_held"}, bus.walk_start, 1);
      check_feat({tag, "_held"}, e);
      stall = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (bus.t_refi_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_eq({tag, "_valid_seen"}, seen, 1);
    check_eq({tag, "_t_refi_out"}, bus.t_refi_out, model_t_refi);
    check_eq({tag, "_start_dropped"}, bus.walk_start, 0);
    @(posedge clk); #1;
    check_eq({tag, "_valid_single"}, bus.t_refi_valid, 0);
  endtask

  // Walker model: done 3 cycles after start, held until start falls.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.walk_done = 1'b0;
    bus.walk_t_refi = 8'd0;
    forever begin
      @(posedge clk); #2;
      bus.walk_t_refi = 8'(model_t_refi);
      if (bus.walk_start && !bus.walk_done) begin
        if (!stall) begin
          wcnt++;
          if (wcnt >= 3) begin
            bus.walk_done = 1'b1;
            wcnt = 0;
          end
        end
      end else if (!bus.walk_start) begin
        bus.walk_done = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    feat_t ea, eb, ec;
    int    ca, cb, cc;
    checks = 0; failures = 0; cyc = 0; stall = 1'b0; exp_overrun = 0;
    model_t_refi = 40;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.ev_req = 1'b0; bus.ev_llc_acc = 1'b0; bus.ev_llc_miss = 1'b0; bus.ev_q_high = 1'b0;
    bus.ev_rb_hit = 1'b0; bus.ev_rb_empty = 1'b0; bus.ev_rb_conf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_feat("reset", '0);
    check_eq("reset_walk_start", bus.walk_start, 0);
    check_eq("reset_t_refi_out", bus.t_refi_out, 32);
    check_eq("reset_t_refi_valid", bus.t_refi_valid, 0);
    check_eq("reset_overrun", bus.overrun_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed windows, each followed by en=0 so the walk completes in isolation.
    drive_window(1, ea, ca); bus.en = 1'b0; check_walk("t1", ea, ca, 0);
    drive_window(2, ea, ca); bus.en = 1'b0; check_walk("t2", ea, ca, 0);
    drive_window(3, ea, ca); bus.en = 1'b0; check_walk("t3", ea, ca, 0);
    drive_window(4, ea, ca); bus.en = 1'b0; check_walk("t4_zero", ea, ca, 0);
    drive_window(5, ea, ca); bus.en = 1'b0; check_walk("t4_half", ea, ca, 0);

    // Random windows, then a back-to-back pair with the walk of the first overlapping the second.
    for (int k = 0; k < 3; k++) begin
      model_t_refi = $urandom_range(0, 255);
      drive_window(6, ea, ca); bus.en = 1'b0; check_walk("rand", ea, ca, 0);
    end
    model_t_refi = $urandom_range(0, 255);
    drive_window(6, ea, ca);
    fork
      drive_window(6, eb, cb);
      check_walk("b2b_a", ea, ca, 0);
    join
    bus.en = 1'b0;
    check_walk("b2b_b", eb, cb, 0);
    check_eq("b2b_overrun", bus.overrun_cnt, exp_overrun);

    // T5: walker stalls past the next close, which is dropped; the window after walks normally.
    model_t_refi = 48;
    drive_window(6, ea, ca);
    fork
      begin
        drive_window(6, eb, cb);
        drive_window(6, ec, cc);
      end
      check_walk("t5_stall", ea, ca, 300);
    join
    exp_overrun = 1;
    check_eq("t5_overrun", bus.overrun_cnt, exp_overrun);
    bus.en = 1'b0;
    check_walk("t5_next", ec, cc, 0);
    check_eq("t5_overrun_after", bus.overrun_cnt, exp_overrun);

    // T6: reset 10 cycles into DIV, then a clean window afterwards.
    model_t_refi = $urandom_range(33, 255);
    drive_window(6, ea, ca);
    bus.en = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    #2;
    check_eq("t6_walk_start", bus.walk_start, 0);
    check_eq("t6_t_refi_out", bus.t_refi_out, 32);
    check_eq("t6_overrun", bus.overrun_cnt, 0);
    check_feat("t6_reset", '0);
    @(posedge clk); #1;
    check_eq("t6_start_quiet", bus.walk_start, 0);
    rst = 1'b0;
    exp_overrun = 0;
    @(posedge clk); #1;
    drive_window(6, ea, ca); bus.en = 1'b0; check_walk("t6_after", ea, ca, 0);
    check_eq("t6_overrun_after", bus.overrun_cnt, exp_overrun);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
